regfile_scoreboard: RTL and testbench

- Parametrised 2-read/1-write integer register file with a per-register busy scoreboard for the pipelined core.
- Decode reserves a destination register and sees whether each source operand is still pending.
- Writeback writes data and releases the reservation.
- Register 0 is hardwired to zero. The stack-pointer register resets to a configurable top-of-memory value.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard_bits.sv | 59 +++++
 rtl/regfile_scoreboard.sv | 81 ++++++++
 tb/tb_regfile_scoreboard.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and the pipeline
// stages that address it (decode, writeback).
package regfile_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NREGS_DEF    = 32;
  localparam int unsigned SP_INDEX_DEF = 29;
  localparam int unsigned SP_RESET_DEF = 4096;

  localparam int unsigned AW_DEF = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy flags with reserve-over-release priority and a registered
// population count of the flags. Register 0 never becomes busy.
module regfile_scoreboard_bits
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             rel_en,
  input  logic [AW-1:0]    rel_addr,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_count
);

  logic             rsv_v;
  logic             rel_v;
  logic             set_new;
  logic             clr_new;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      count_nxt;

  assign rsv_v = rsv_en && (rsv_addr != '0);
  assign rel_v = rel_en && (rel_addr != '0);

  // Next flag vector (release first, reserve overrides) and count delta.
  // A bit counts as newly cleared only if it was set and the same-cycle
  // reserve does not target it; newly set only if it was clear.
  always_comb begin
    busy_nxt = busy;
    if (rel_v) busy_nxt[rel_addr] = 1'b0;
    if (rsv_v) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;

    set_new = rsv_v && !busy[rsv_addr];
    clr_new = rel_v && busy[rel_addr] && !(rsv_v && (rsv_addr == rel_addr));

    count_nxt = busy_count;
    if (set_new && !clr_new)
      count_nxt = busy_count + (AW+1)'(1);
    else if (clr_new && !set_new)
      count_nxt = busy_count - (AW+1)'(1);
  end

  // Busy flags and count, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write integer register file with busy scoreboard.
// Register 0 reads as zero; register SP_INDEX resets to SP_RESET.
// Optional macro REGFILE_BYPASS_EN: same-cycle writeback forwarding to the
// read ports (data and busy).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEF,
  parameter  int unsigned NREGS    = NREGS_DEF,
  parameter  int unsigned SP_INDEX = SP_INDEX_DEF,
  parameter  int unsigned SP_RESET = SP_RESET_DEF,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra_addr,
  output logic [XLEN-1:0] ra_data,
  output logic            ra_busy,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] rb_data,
  output logic            rb_busy,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW:0]     busy_count
);

  localparam logic [XLEN-1:0] SP_RESET_W = XLEN'(SP_RESET);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wb_v;

  assign wb_v = wb_en && (wb_addr != '0);

  regfile_scoreboard_bits #(
    .NREGS (NREGS)
  ) u_bits (
    .clk        (clk),
    .rst        (rst),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rel_en     (wb_en),
    .rel_addr   (wb_addr),
    .busy       (busy),
    .busy_count (busy_count)
  );

  // Register storage: async reset to zero except the stack pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= (i == SP_INDEX) ? SP_RESET_W : '0;
    end else if (wb_v) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Combinational read ports with optional writeback forwarding.
  always_comb begin
    ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
    rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];
    ra_busy = busy[ra_addr];
    rb_busy = busy[rb_addr];
`ifdef REGFILE_BYPASS_EN
    // A forwarded port is no longer pending unless a new producer is being
    // reserved on the same register this cycle.
    if (wb_v && (wb_addr == ra_addr)) begin
      ra_data = wb_data;
      ra_busy = rsv_en && (rsv_addr == ra_addr);
    end
    if (wb_v && (wb_addr == rb_addr)) begin
      rb_data = wb_data;
      rb_busy = rsv_en && (rsv_addr == rb_addr);
    end
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
// Expectations follow REGFILE_BYPASS_EN when the macro is defined.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  reg_addr_t ra_addr, rb_addr, rsv_addr, wb_addr;
  word_t     ra_data, rb_data, wb_data;
  logic      ra_busy, rb_busy, rsv_en, wb_en;
  logic [5:0] busy_count;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .ra_addr    (ra_addr),
    .ra_data    (ra_data),
    .ra_busy    (ra_busy),
    .rb_addr    (rb_addr),
    .rb_data    (rb_data),
    .rb_busy    (rb_busy),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rsv_en = 1'b0; rsv_addr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ra_addr = 5'd29; rb_addr = 5'd0;
    #1;
    check("rst_sp", ra_data, 64'd4096);
    check("rst_x0", rb_data, 64'd0);
    check("rst_cnt", busy_count, 64'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Register 0 is hardwired
    rsv_en = 1'b1; rsv_addr = 5'd0;
    step();
    idle();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
    step();
    idle();
    ra_addr = 5'd0; #1;
    check("x0_data", ra_data, 64'd0);
    check("x0_busy", ra_busy, 64'd0);
    check("x0_cnt", busy_count, 64'd0);

    // Full lifecycle on x5
    rsv_en = 1'b1; rsv_addr = 5'd5;
    step();
    idle();
    ra_addr = 5'd5; #1;
    check("life_busy", ra_busy, 64'd1);
    check("life_cnt1", busy_count, 64'd1);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h12345678;
    step();
    idle(); #1;
    check("life_data", ra_data, 64'h12345678);
    check("life_free", ra_busy, 64'd0);
    check("life_cnt0", busy_count, 64'd0);

    // Collision: reserve wins over release on the same register
    rsv_en = 1'b1; rsv_addr = 5'd7;
    step();
    rsv_en = 1'b1; rsv_addr = 5'd7;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5A5A5;
    step();
    idle();
    ra_addr = 5'd7; #1;
    check("coll_busy", ra_busy, 64'd1);
    check("coll_data", ra_data, 64'hA5A5A5A5);
    check("coll_cnt", busy_count, 64'd1);
    // Reserve x8 while releasing x7: net zero
    rsv_en = 1'b1; rsv_addr = 5'd8;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000005A;
    step();
    idle();
    ra_addr = 5'd8; rb_addr = 5'd7; #1;
    check("swap_cnt", busy_count, 64'd1);
    check("swap_x8", ra_busy, 64'd1);
    check("swap_x7", rb_busy, 64'd0);
    check("swap_x7d", rb_data, 64'h5A);
    // Reserve + writeback of a non-busy register: becomes busy, +1
    rsv_en = 1'b1; rsv_addr = 5'd9;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    step();
    idle();
    ra_addr = 5'd9; #1;
    check("new_busy", ra_busy, 64'd1);
    check("new_cnt", busy_count, 64'd2);
    check("new_data", ra_data, 64'h99);
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h88;
    step();
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    step();
    // Uncounted writeback to a non-busy register
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hAA;
    step();
    idle();
    ra_addr = 5'd10; #1;
    check("unc_data", ra_data, 64'hAA);
    check("unc_busy", ra_busy, 64'd0);
    check("drain_cnt", busy_count, 64'd0);

    // Forwarding
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    step();
    idle();
    ra_addr = 5'd3; rb_addr = 5'd4;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h22;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_data", ra_data, 64'h22);
    check("byp_rsvbusy", ra_busy, 64'd1);
`else
    check("byp_data", ra_data, 64'h11);
    check("byp_rsvbusy", ra_busy, 64'd0);
`endif
    check("byp_other", rb_data, 64'd0);
    step();
    idle(); #1;
    check("byp_after", ra_data, 64'h22);
    check("byp_cnt", busy_count, 64'd1);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_clr", ra_busy, 64'd0);
`else
    check("byp_clr", ra_busy, 64'd1);
`endif
    step();
    idle(); #1;
    check("byp_cnt0", busy_count, 64'd0);

    // Saturation
    for (int i = 1; i < 32; i++) begin
      rsv_en = 1'b1; rsv_addr = 5'(i);
      step();
    end
    idle();
    ra_addr = 5'd31; rb_addr = 5'd1; #1;
    check("sat_cnt", busy_count, 64'd31);
    check("sat_x31", ra_busy, 64'd1);
    check("sat_x1", rb_busy, 64'd1);

    // Mid-cycle asynchronous reset
    @(negedge clk);
    rst = 1'b1;
    ra_addr = 5'd5; rb_addr = 5'd29;
    #1;
    check("arst_cnt", busy_count, 64'd0);
    check("arst_x5", ra_data, 64'd0);
    check("arst_busy", ra_busy, 64'd0);
    check("arst_sp", rb_data, 64'd4096);
    ra_addr = 5'd31; #1;
    check("arst_x31", ra_busy, 64'd0);
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
